// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if: the input and output streams of the MixColumns stage,
// each a valid/ready handshake.
//   in_valid_i / in_ready_o  : state offered by shift_rows / stage can take it
//   in_data_i  [127:0]       : state, byte (col c,row r) at [(c*4+r)*8 +: 8]
//   in_last_i                : final round, state passes through unmixed
//   inv_i                    : InvMixColumns select (MIX_COLUMNS_INV_EN only)
//   out_valid_o / out_ready_i: result offered / consumer takes it
//   out_data_o [127:0]       : mixed or bypassed state
// slave is the stage itself and master is the upstream/downstream environment.
// Macro: MIX_COLUMNS_INV_EN adds inv_i.
interface mix_columns_seq_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         in_last_i;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_i;
`endif
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_data_o;

    modport slave (
`ifdef MIX_COLUMNS_INV_EN
        input  inv_i,
`endif
        input  in_valid_i,
        input  in_data_i,
        input  in_last_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
`ifdef MIX_COLUMNS_INV_EN
        output inv_i,
`endif
        output in_valid_i,
        output in_data_i,
        output in_last_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES MixColumns stage placed after shift_rows.
// Mixes COLS_PER_CYCLE columns per BUSY cycle (NGRP = 4/COLS_PER_CYCLE cycles
// per block). A block flagged last is passed through unmixed with identical
// latency, because the final AES round has no MixColumns.
// Ports:
//   clk   : clock, posedge
//   rst_n : synchronous active-low reset
//   bus   : mix_columns_seq_if.slave (in/out valid-ready streams)
// Macro: MIX_COLUMNS_INV_EN adds inv_i and InvMixColumns logic.
//
// state | meaning
// IDLE  | ready for a block, in_ready_o=1
// BUSY  | mixing one column group per cycle
// DONE  | result presented, waiting for out_ready_i
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst_n,
    mix_columns_seq_if.slave bus
);

    localparam int         NGRP     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP = 2'(NGRP - 1);
    // With 4 columns per cycle the group counter never leaves 0, so the
    // truncated stride of 0 still yields the right column index.
    localparam logic [1:0] STRIDE   = 2'(COLS_PER_CYCLE % 4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = a[7:0];
        a1 = a[15:8];
        a2 = a[23:16];
        a3 = a[31:24];
        r0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        r3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {r3, r2, r1, r0};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Multiples 9, b, d, e of one byte, built from x2/x4/x8.
    function automatic logic [31:0] mul_9bde(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return {x8 ^ x4 ^ x2, x8 ^ x4 ^ a, x8 ^ x2 ^ a, x8 ^ a};
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] a);
        logic [31:0] m0, m1, m2, m3;
        logic [7:0]  r0, r1, r2, r3;
        // m*[7:0]=9x, [15:8]=bx, [23:16]=dx, [31:24]=ex
        m0 = mul_9bde(a[7:0]);
        m1 = mul_9bde(a[15:8]);
        m2 = mul_9bde(a[23:16]);
        m3 = mul_9bde(a[31:24]);
        r0 = m0[31:24] ^ m1[15:8]  ^ m2[23:16] ^ m3[7:0];
        r1 = m0[7:0]   ^ m1[31:24] ^ m2[15:8]  ^ m3[23:16];
        r2 = m0[23:16] ^ m1[7:0]   ^ m2[31:24] ^ m3[15:8];
        r3 = m0[15:8]  ^ m1[23:16] ^ m2[7:0]   ^ m3[31:24];
        return {r3, r2, r1, r0};
    endfunction
`endif

    logic [1:0]   state_q, state_d;
    logic [1:0]   grp_cnt_q, grp_cnt_d;
    logic [127:0] blk_q, blk_d;
    logic         last_q, last_d;
    logic [127:0] out_data_q, out_data_d;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv_q, inv_d;
`endif

    // Captured block is overwritten in place, one column group per cycle;
    // each column is read exactly once so no separate result register is needed.
    logic [127:0] mixed;
    logic [1:0]   col;

    always_comb begin
        mixed = blk_q;
        col   = 2'd0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col = grp_cnt_q * STRIDE + 2'(k);
            if (last_q) begin
                mixed[{col, 5'd0} +: 32] = blk_q[{col, 5'd0} +: 32];
            end else begin
`ifdef MIX_COLUMNS_INV_EN
                mixed[{col, 5'd0} +: 32] = inv_q ? mix_inv(blk_q[{col, 5'd0} +: 32])
                                                 : mix_fwd(blk_q[{col, 5'd0} +: 32]);
`else
                mixed[{col, 5'd0} +: 32] = mix_fwd(blk_q[{col, 5'd0} +: 32]);
`endif
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grp_cnt_d  = grp_cnt_q;
        blk_d      = blk_q;
        last_d     = last_q;
        out_data_d = out_data_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d      = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    blk_d     = bus.in_data_i;
                    last_d    = bus.in_last_i;
`ifdef MIX_COLUMNS_INV_EN
                    inv_d     = bus.inv_i;
`endif
                    grp_cnt_d = 2'd0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                blk_d = mixed;
                if (grp_cnt_q == LAST_GRP) begin
                    out_data_d = mixed;
                    grp_cnt_d  = 2'd0;
                    state_d    = S_DONE;
                end else begin
                    grp_cnt_d = grp_cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grp_cnt_q  <= 2'd0;
            blk_q      <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grp_cnt_q  <= grp_cnt_d;
            blk_q      <= blk_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q      <= inv_d;
`endif
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.out_data_o  = out_data_q;

endmodule
